denoise_window_sequencer: RTL and testbench

Controller for the paddle-localization denoise path. It sits between the colour-mask pixel source and the `sliding_window` → `denoise_color_masked_image` pair, and sequences the line buffer. After reset it primes the window with zero pixels. It then accepts one frame of mask pixels through a valid/ready handshake and drives the window shift enable. At end of frame it injects flush pixels so that the window drains completely and zero padding is in place for the next frame. It also publishes, each time the window is centred on a real pixel, that pixel's row/column coordinate and a border flag.

---
 rtl/denoise_pkg.sv | 25 ++
 rtl/frame_coord_counter.sv | 42 ++++
 rtl/denoise_window_sequencer.sv | 156 +++++++++++++++
 tb/tb_denoise_window_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/denoise_pkg.sv
// Shared types and parameter derivations for the denoise window sequencer.
package denoise_pkg;

  typedef enum logic [2:0] {
    StPrime,
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  function automatic int unsigned half_of(input int unsigned n_size);
    return (n_size - 1) / 2;
  endfunction

  // Shifts needed to carry a freshly entered pixel to the window centre tap.
  function automatic int unsigned lag_of(input int unsigned width, input int unsigned n_size);
    return half_of(n_size) * width + half_of(n_size);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned lag);
    return $clog2(lag + 1);
  endfunction

endpackage

// File: rtl/frame_coord_counter.sv
// Raster row/column counter: advances on en_i, col wraps at WIDTH-1, row at HEIGHT-1.
module frame_coord_counter #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned CRD_W  = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  output logic [CRD_W-1:0] row_o,
  output logic [CRD_W-1:0] col_o
);

  logic [CRD_W-1:0] row_d, row_q, col_d, col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (en_i) begin
      if (col_q == CRD_W'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == CRD_W'(HEIGHT - 1)) ? '0 : row_q + CRD_W'(1);
      end else begin
        col_d = col_q + CRD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/denoise_window_sequencer.sv
// Line-buffer sequencer: primes, feeds and flushes the sliding window and tags centre pixels.
// Optional DENOISE_BORDER_FLAG_EN enables the ctr_border comparators (else tied to 0).
module denoise_window_sequencer
  import denoise_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned N_SIZE = 5,
  parameter int unsigned COLORS = 2,
  parameter int unsigned CRD_W  = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COLORS-1:0] in_data,
  output logic              win_en,
  output logic [COLORS:0]   win_data,
  output logic              ctr_valid,
  output logic [CRD_W-1:0]  ctr_row,
  output logic [CRD_W-1:0]  ctr_col,
  output logic              ctr_border,
  output logic              frame_start,
  output logic              frame_done
);

  localparam int unsigned LAG   = lag_of(WIDTH, N_SIZE);
  localparam int unsigned CNT_W = cnt_width(LAG);

  state_e state_d, state_q;
  logic [CNT_W-1:0] shift_cnt_d, shift_cnt_q, aux_cnt_d, aux_cnt_q;
  logic win_en_d, win_en_q, ctr_pend_d, ctr_pend_q, ctr_valid_d, ctr_valid_q;
  logic [COLORS:0] win_data_d, win_data_q;
  logic [CRD_W-1:0] ctr_row_d, ctr_row_q, ctr_col_d, ctr_col_q;
  logic ctr_border_d, ctr_border_q, frame_start_d, frame_start_q;
  logic done_pend_d, done_pend_q, frame_done_d, frame_done_q;
  logic accept, in_last, shift, real_pix, border;
  logic [CRD_W-1:0] in_row, in_col, cen_row, cen_col;

  assign in_ready = (state_q == StIdle) || (state_q == StRun);
  assign accept   = in_valid & in_ready;
  assign in_last  = (in_row == CRD_W'(HEIGHT - 1)) && (in_col == CRD_W'(WIDTH - 1));

  frame_coord_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CRD_W(CRD_W)) u_in_coord (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (accept),
    .row_o  (in_row),
    .col_o  (in_col)
  );

  // ctr_pend_q marks the cycle the centring shift is on win_en; coordinates advance then.
  frame_coord_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CRD_W(CRD_W)) u_ctr_coord (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (ctr_pend_q),
    .row_o  (cen_row),
    .col_o  (cen_col)
  );

`ifdef DENOISE_BORDER_FLAG_EN
  localparam int unsigned HALF = half_of(N_SIZE);
  assign border = (cen_row < CRD_W'(HALF)) || (cen_row > CRD_W'(HEIGHT - 1 - HALF)) ||
                  (cen_col < CRD_W'(HALF)) || (cen_col > CRD_W'(WIDTH - 1 - HALF));
`else
  assign border = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    aux_cnt_d   = aux_cnt_q;
    shift       = 1'b0;
    real_pix    = 1'b0;
    unique case (state_q)
      StPrime, StFlush: begin
        shift     = 1'b1;
        aux_cnt_d = aux_cnt_q + CNT_W'(1);
        if (aux_cnt_q == CNT_W'(LAG - 1)) begin
          aux_cnt_d = '0;
          state_d   = (state_q == StPrime) ? StIdle : StDone;
        end
      end
      StIdle, StRun: begin
        if (accept) begin
          shift    = 1'b1;
          real_pix = 1'b1;
          state_d  = in_last ? StFlush : StRun;
        end
      end
      StDone: begin
        shift_cnt_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StPrime;
    endcase

    // Prime shifts belong to no frame, so they neither count nor centre a pixel.
    ctr_pend_d = shift && (state_q != StPrime) && (shift_cnt_q >= CNT_W'(LAG));
    if (shift && (state_q != StPrime) && (shift_cnt_q != CNT_W'(LAG))) begin
      shift_cnt_d = shift_cnt_q + CNT_W'(1);
    end

    win_en_d      = shift;
    win_data_d    = real_pix ? {1'b1, in_data} : '0;
    ctr_valid_d   = ctr_pend_q;
    ctr_row_d     = ctr_pend_q ? cen_row : '0;
    ctr_col_d     = ctr_pend_q ? cen_col : '0;
    ctr_border_d  = ctr_pend_q & border;
    frame_start_d = accept && (state_q == StIdle);
    done_pend_d   = (state_q == StDone);
    frame_done_d  = done_pend_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StPrime;
      shift_cnt_q   <= '0;
      aux_cnt_q     <= '0;
      win_en_q      <= 1'b0;
      win_data_q    <= '0;
      ctr_pend_q    <= 1'b0;
      ctr_valid_q   <= 1'b0;
      ctr_row_q     <= '0;
      ctr_col_q     <= '0;
      ctr_border_q  <= 1'b0;
      frame_start_q <= 1'b0;
      done_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_cnt_q   <= shift_cnt_d;
      aux_cnt_q     <= aux_cnt_d;
      win_en_q      <= win_en_d;
      win_data_q    <= win_data_d;
      ctr_pend_q    <= ctr_pend_d;
      ctr_valid_q   <= ctr_valid_d;
      ctr_row_q     <= ctr_row_d;
      ctr_col_q     <= ctr_col_d;
      ctr_border_q  <= ctr_border_d;
      frame_start_q <= frame_start_d;
      done_pend_q   <= done_pend_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign win_en      = win_en_q;
  assign win_data    = win_data_q;
  assign ctr_valid   = ctr_valid_q;
  assign ctr_row     = ctr_row_q;
  assign ctr_col     = ctr_col_q;
  assign ctr_border  = ctr_border_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_denoise_window_sequencer.sv
// Scoreboard bench for denoise_window_sequencer on an 8x4 frame with a 3x3 window.
module tb_denoise_window_sequencer;

  localparam int W = 8, H = 4, N = 3, C = 2, CW = 13;
  localparam int HALF = (N - 1) / 2;
  localparam int LAG = HALF * W + HALF;

  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0;
  logic [C-1:0] in_data = '0;
  logic in_ready, win_en, ctr_valid, ctr_border, frame_start, frame_done;
  logic [C:0] win_data;
  logic [CW-1:0] ctr_row, ctr_col;

  denoise_window_sequencer #(.WIDTH(W), .HEIGHT(H), .N_SIZE(N), .COLORS(C), .CRD_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .win_en     (win_en),
    .win_data   (win_data),
    .ctr_valid  (ctr_valid),
    .ctr_row    (ctr_row),
    .ctr_col    (ctr_col),
    .ctr_border (ctr_border),
    .frame_start(frame_start),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] c;
    logic          b;
  } ctr_t;

  ctr_t       ctr_q[$];
  logic [C:0] win_q[$];
  int total = 0, bad = 0;
  int cyc = 0, last_ctr_cyc = -10, first_ctr_cyc = -1, done_cnt = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit border_model(input int r, input int c);
`ifdef DENOISE_BORDER_FLAG_EN
    return (r < HALF) || (r > H - 1 - HALF) || (c < HALF) || (c > W - 1 - HALF);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: pops expected shifts and centre coordinates whenever the DUT presents them.
  initial begin
    ctr_t       ce;
    logic [C:0] we;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (win_en) begin
          if (win_q.size() == 0) chk("win_en spurious", win_en, 0);
          else begin
            we = win_q.pop_front();
            chk("win_data", win_data, we);
          end
        end
        if (ctr_valid) begin
          if (ctr_q.size() == 0) chk("ctr_valid spurious", ctr_valid, 0);
          else begin
            ce = ctr_q.pop_front();
            chk("ctr_row", ctr_row, ce.r);
            chk("ctr_col", ctr_col, ce.c);
            chk("ctr_border", ctr_border, ce.b);
            if (first_ctr_cyc < 0) first_ctr_cyc = cyc;
            if (ctr_q.size() == 0) last_ctr_cyc = cyc;
          end
        end
        if (frame_done) begin
          chk("frame_done timing", cyc, last_ctr_cyc + 1);
          done_cnt++;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst in_ready", in_ready, 0);
    chk("rst win_en", win_en, 0);
    chk("rst win_data", win_data, 0);
    chk("rst ctr_valid", ctr_valid, 0);
    chk("rst ctr_row", ctr_row, 0);
    chk("rst ctr_col", ctr_col, 0);
    chk("rst ctr_border", ctr_border, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst frame_done", frame_done, 0);
  endtask

  task automatic release_and_prime();
    int cnt = 0;
    bit any_ctr = 1'b0, ready_seen = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < LAG; i++) win_q.push_back('0);
    mon_en = 1'b1;
    for (int i = 0; i < 60 && !ready_seen; i++) begin
      @(negedge clk);
      #1;
      if (win_en) cnt++;
      if (ctr_valid) any_ctr = 1'b1;
      if (in_ready) ready_seen = 1'b1;
    end
    chk("prime in_ready rises", ready_seen, 1);
    chk("prime shifts", cnt, LAG);
    chk("prime ctr_valid", any_ctr, 0);
  endtask

  // mode 0: continuous, 1: alternate 1/0, 2: random valid. abort resets mid-flush.
  task automatic run_frame(input int mode, input bit abort);
    int acc = 0, acc10 = -1, guard = 0, d0, low = 0;
    bit fs_pend = 1'b0, rdy_high = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) ctr_q.push_back(ctr_t'{CW'(r), CW'(c), border_model(r, c)});
    first_ctr_cyc = -1;
    d0 = done_cnt;
    while (acc < W * H && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
      if (fs_pend) begin
        chk("frame_start", frame_start, 1);
        fs_pend = 1'b0;
      end
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2) == 1;
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      in_data = C'($urandom);
      if (in_valid && in_ready) begin
        win_q.push_back({1'b1, in_data});
        acc++;
        if (acc == 1) fs_pend = 1'b1;
        if (acc == LAG + 1) acc10 = cyc;
      end
    end
    if (acc < W * H) chk("accept budget", acc, W * H);
    for (int i = 0; i < LAG; i++) win_q.push_back('0);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready after last accept", in_ready, 0);
    if (abort) begin
      repeat (3) @(negedge clk);
      #1;
      chk("in_ready in flush", in_ready, 0);
      reset_n = 1'b0;
      @(negedge clk);
      mon_en = 1'b0;
      #1;
      check_reset_outputs();
      ctr_q.delete();
      win_q.delete();
      release_and_prime();
      return;
    end
    low = 1;
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      @(negedge clk);
      #1;
      if (!rdy_high) begin
        if (in_ready) rdy_high = 1'b1;
        else low++;
      end
    end
    chk("frame_done seen", done_cnt, d0 + 1);
    chk("flush ready-low cycles", low, LAG + 1);
    chk("first ctr latency", first_ctr_cyc, acc10 + 2);
    chk("ctr queue drained", ctr_q.size(), 0);
    chk("win queue drained", win_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    release_and_prime();
    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(0, 1'b1);
    run_frame(2, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
